uart_rx_sampler: RTL and testbench

- UART receiver; sits directly downstream of the transmitter in the UART top and consumes its `serial_out`.
- Oversamples the line with the shared 16x baud enable (`baudrate_clk`, one `clk` cycle wide per tick).
- Validates the start bit at mid-bit, shifts data LSB-first, checks the stop bit.
- Presents the received byte on `parallel_out` with a one-cycle valid strobe.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx_sampler.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and default
// frame geometry.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // 100 MHz system clock, 16x oversampling of 9600 baud.
    localparam int CLKS_PER_TICK  = 100_000_000 / (16 * 9600);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;
    localparam logic [2:0] ST_BREAK  = BREAK;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for the asynchronous serial line; resets to the
// idle (high) level so no false start is seen coming out of reset.
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: mid-bit start validation, LSB-first data,
// stop-bit check. Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baudrate_clk,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        if (baudrate_clk) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = '0;
                            bit_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        // First received bit drifts down to bit 0 after DATA_BITS shifts.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_bad_d = ^{shift_q, rx_s};
                        state_d   = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a start bit right after it be caught.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            out_d   = shift_q;
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_bad_q;
`endif
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign parallel_out = out_q;
    assign rx_valid     = valid_q;
    assign frame_err    = ferr_q;
    assign rx_busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed frame table, multi-cycle corner sequences
// and random frames scored against a frame-level expectation queue.
module tb_uart_rx_sampler;
    import uart_pkg::*;

    // Ticks come every few clocks instead of CLKS_PER_TICK so runs stay short;
    // the receiver only ever observes the enable itself.
    localparam int TICK_DIV = 4;
    localparam int OS       = OVERSAMPLE_DEF;

    logic       clk          = 1'b0;
    logic       rst          = 1'b0;
    logic       baudrate_clk = 1'b0;
    logic       serial_in    = 1'b1;
    logic [7:0] parallel_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
    logic       dut_perr;
    bit         tick_en      = 1'b1;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         n_ferr   = 0;
    logic [7:0] last_good = 8'h00;
    // Expected frame outcomes, oldest first: {parity_err, frame_err, data}.
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;

    uart_rx_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .baudrate_clk (baudrate_clk),
        .serial_in    (serial_in),
        .parallel_out (parallel_out),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (dut_perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign dut_perr = 1'b0;
`endif

    // ---------------- clock / tick / reset ----------------
    always #5 clk = ~clk;

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            baudrate_clk = tick_en && (div == TICK_DIV - 1);
            div = (div + 1) % TICK_DIV;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (baudrate_clk !== 1'b1);
        end
        #1;
    endtask

    task automatic do_freeze();
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        tick_en = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("freeze_busy", 32'(rx_busy), 32'd1);
        check("freeze_out", 32'(parallel_out), 32'(last_good));
        check("freeze_no_strobe", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
        tick_en = 1'b1;
    endtask

    // Drives one frame and records what the receiver must report for it.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit pflip,
                              input int hold_low, input int freeze_at);
        logic pbad;
        pbad = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad = pflip;
`endif
        if (stop_ok) exp_q.push_back({pbad, 1'b0, data});
        else         exp_q.push_back({1'b0, 1'b1, 8'h00});
        serial_in = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            serial_in = data[i];
            wait_ticks(OS);
            if (i == freeze_at) do_freeze();
        end
`ifdef UART_RX_PARITY_EN
        serial_in = (^data) ^ pflip;
        wait_ticks(OS);
`endif
        if (stop_ok) begin
            serial_in = 1'b1;
            wait_ticks(OS);
        end else begin
            serial_in = 1'b0;
            wait_ticks(OS + hold_low);
            serial_in = 1'b1;
            wait_ticks(2);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst && (rx_valid || frame_err)) begin
            check("strobe_exclusive", 32'(rx_valid & frame_err), 32'd0);
            if (rx_valid) n_valid++;
            if (frame_err) n_ferr++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b out=%0h, expected no strobe (t=%0t)",
                         rx_valid, frame_err, parallel_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", 32'(frame_err), 32'(mon_e[8]));
                if (!mon_e[8]) begin
                    check("rx_data", 32'(parallel_out), 32'(mon_e[7:0]));
`ifdef UART_RX_PARITY_EN
                    check("parity_err", 32'(dut_perr), 32'(mon_e[9]));
`endif
                    last_good = mon_e[7:0];
                end else begin
                    check("held_out", 32'(parallel_out), 32'(last_good));
                end
            end
        end
`ifdef UART_RX_PARITY_EN
        if (rst && dut_perr && !rx_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL lone_parity_err: parity_err=1 rx_valid=0, expected pulse with rx_valid");
        end
`endif
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
        int         hold;
        logic [7:0] exp_out;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        int v0;
        int f0;
        logic [7:0] rd;

        vecs[0] = '{8'h75, 1'b1, 20, 0,  8'h75, 1, 0};
        vecs[1] = '{8'h33, 1'b1, 10, 0,  8'h33, 1, 0};
        vecs[2] = '{8'h79, 1'b1, 0,  0,  8'h79, 1, 0};
        vecs[3] = '{8'h5A, 1'b0, 5,  24, 8'h79, 0, 1};
        vecs[4] = '{8'hC3, 1'b1, 10, 0,  8'hC3, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(parallel_out), 32'h0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        rst = 1'b1;
        wait_ticks(4);

        for (int k = 0; k < 5; k++) begin
            serial_in = 1'b1;
            wait_ticks(vecs[k].gap);
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[k].data, vecs[k].stop_ok, 1'b0, vecs[k].hold, -1);
            check("vec_out", 32'(parallel_out), 32'(vecs[k].exp_out));
            check("vec_valid_cnt", 32'(n_valid - v0), 32'(vecs[k].exp_valid));
            check("vec_err_cnt", 32'(n_ferr - f0), 32'(vecs[k].exp_err));
            check("vec_idle", 32'(rx_busy), 32'd0);
        end

        // False start: a 4-tick low pulse must be rejected at mid-bit.
        v0 = n_valid;
        f0 = n_ferr;
        serial_in = 1'b0;
        wait_ticks(2);
        check("false_start_busy", 32'(rx_busy), 32'd1);
        wait_ticks(2);
        serial_in = 1'b1;
        wait_ticks(12);
        check("false_start_idle", 32'(rx_busy), 32'd0);
        check("false_start_no_strobe", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0, 0, -1);
        check("after_false_start", 32'(parallel_out), 32'hA5);

        // Reset in the middle of data bit 4 of 0xFF.
        serial_in = 1'b1;
        wait_ticks(6);
        check("pre_reset_out", 32'(parallel_out), 32'hA5);
        serial_in = 1'b0;
        wait_ticks(OS);
        serial_in = 1'b1;
        wait_ticks(4 * OS + OS / 2);
        rst = 1'b0;
        #1;
        check("midframe_reset_out", 32'(parallel_out), 32'h0);
        check("midframe_reset_valid", 32'(rx_valid), 32'd0);
        check("midframe_reset_ferr", 32'(frame_err), 32'd0);
        check("midframe_reset_busy", 32'(rx_busy), 32'd0);
        exp_q.delete();
        last_good = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ticks(20);
        v0 = n_valid;
        send_frame(8'h0F, 1'b1, 1'b0, 0, -1);
        check("after_reset_out", 32'(parallel_out), 32'h0F);
        check("after_reset_valid_cnt", 32'(n_valid - v0), 32'd1);

        // Tick enable held low mid-frame: everything must hold, then resume.
        wait_ticks(3);
        send_frame(8'h96, 1'b1, 1'b0, 0, 3);
        check("after_freeze_out", 32'(parallel_out), 32'h96);

`ifdef UART_RX_PARITY_EN
        wait_ticks(3);
        send_frame(8'h75, 1'b1, 1'b0, 0, -1);
        check("parity_ok_out", 32'(parallel_out), 32'h75);
        wait_ticks(3);
        send_frame(8'h75, 1'b1, 1'b1, 0, -1);
        check("parity_bad_out", 32'(parallel_out), 32'h75);
`endif

        // Random frames: data, gaps (incl. back-to-back), bad stops, parity flips.
        for (int k = 0; k < 30; k++) begin
            serial_in = 1'b1;
            wait_ticks($urandom_range(0, 8));
            rd = 8'($urandom_range(0, 255));
            send_frame(rd, ($urandom_range(0, 5) != 0), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 30), -1);
        end
        serial_in = 1'b1;
        wait_ticks(4);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_out", 32'(parallel_out), 32'(last_good));
        check("final_idle", 32'(rx_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
